vga_display_fetch: RTL
======================

Name: vga_display_fetch

Overview:
- Display-side consumer of the dual-port VRAM.
- Generates 640x480@60 VGA timing and drives the VRAM display read address.
- Captures the returned byte and serialises it into 2bpp pixels, expanded 4x4 (160x120 source, 40 bytes/row, 4800 bytes).
- Maps pixels through a 4-entry palette to RGB plus syncs. Sits between the VRAM display port and the DAC/pins.

Parameters:
- BYTES_PER_ROW, 40, source bytes per source row (160 px at 2bpp)
- PAL0, 9'h000, palette entry 0 {R[2:0],G[2:0],B[2:0]}
- PAL1, 9'h007, palette entry 1
- PAL2, 9'h038, palette entry 2
- PAL3, 9'h1FF, palette entry 3

Ports:
- clk  in  1  pixel clock (25.175 MHz); all logic on posedge
- rst_n  in  1  asynchronous active-low reset
- displayAddr  out  13  VRAM display-side address, registered
- displayRdData  in  8  VRAM display read data, valid 1 cycle after address is sampled
- hsync  out  1  horizontal sync, active low
- vsync  out  1  vertical sync, active low
- red  out  3  red level
- green  out  3  green level
- blue  out  3  blue level
- vblank  out  1  high while v >= 480 (host-safe update window)

Behaviour:
- Counters h 0..799 and v 0..524. h wraps 799->0 and increments v; v wraps 524->0.
- Horizontal: visible 0-639, front porch 640-655, sync 656-751, back porch 752-799.
- Vertical: visible 0-479, front porch 480-489, sync 490-491, back porch 492-524.
- Reset (async assert): h=0, v=0, displayAddr=0, hsync=1, vsync=1, rgb=0, vblank=0, pixel shift reg=0. Release takes effect on the next posedge.
- Output latency: hsync/vsync/vblank/rgb are registered and reflect counter position (h,v) in the cycle after (h,v). Syncs and colour stay mutually aligned.
- Visible area = h<640 && v<480. Outside it, rgb=0 regardless of the shift register.
- Group g (0..39) covers h=16g..16g+15 of line v and uses source row r=v>>2.
- Address = r*BYTES_PER_ROW + g, computed with shift-add (r*32 + r*8), no multiplier.
- Fetch schedule for group g (cycle indices mod 800, on the line preceding when g=0):
  - displayAddr updated at the edge ending cycle 16g-4.
  - VRAM samples it at the edge ending 16g-3.
  - Data is valid from cycle 16g-2.
  - Shift register loads displayRdData at the edge ending 16g-1.
- g=0 fetch runs at h=796..799 of line v-1, using the next line's row. For v=0 it runs on line 524 with row 0.
- No fetches for lines v>=480 except the line-524 prefetch. During blank lines displayAddr holds its last value.
- Pixel index = shift[7:6] for h%16 in 0-3, [5:4] for 4-7, [3:2] for 8-11, [1:0] for 12-15.
- Each source row is refetched on all 4 display lines; there is no line buffer.
- Max address 119*40+39 = 4799. Addresses >= 4800 are never issued.
- displayRdData is don't-care in cycles other than the capture cycle.

Optional Feature:
- Macro VGA_PALETTE_WR_EN.
- When defined:
  - Adds palWrEn (in, 1), palWrIdx (in, 2) and palWrData (in, 9).
  - Palette is 4 registers reset to PAL0..PAL3. palWrEn writes palWrData into entry palWrIdx at the posedge.
  - A new colour is visible from pixels whose lookup occurs after that edge. Same-cycle lookup sees the old value.
- When undefined: palette is constant PAL0..PAL3 and the extra ports do not exist.

Test Plan:
- Reset mid-frame (assert rst_n=0 at v=200,h=300, release) -> outputs at reset values immediately. First hsync low at h=656 (output cycle 657); vsync low for output lines 490-491; period 800x525 = 420000 clocks.
- VRAM model returns byte at addr = addr[7:0]. Frame run -> displayAddr sequence 0..39 repeated 4 times for lines 0-3, then 40..79. Max 4799. Load occurs 3 cycles after each address change.
- Byte 8'b00_01_10_11 at address 0 -> line 0, h=0..15 outputs PAL0 x4, PAL1 x4, PAL2 x4, PAL3 x4 (1-cycle delayed).
- h=640..799 and v=480..524 -> rgb=0 with all-3 data; vblank=1 exactly for output lines 480-524.
- Wrap check: at v=524,h=796 displayAddr=0; line 0 group 0 shows byte 0, not row-120 data.
- VGA_PALETTE_WR_EN: write idx 3 = 9'h1C0 at v=10,h=0 -> PAL3 pixels read 9'h1C0 from h=1 onward; after reset the entry returns to 9'h1FF.

Source files
------------

// File: rtl/vga_display_fetch.sv
// vga_display_fetch: 640x480@60 VGA timing generator and VRAM display-side fetch.
// Reads one byte per 16 pixels, expands 2bpp source pixels 4x4 and maps them through a palette.
//
// Ports:
//   clk            pixel clock, all logic on posedge
//   rst_n          asynchronous active-low reset
//   displayAddr    VRAM display read address (registered)
//   displayRdData  VRAM read data, valid one cycle after the address is sampled
//   hsync/vsync    active-low syncs, registered
//   red/green/blue 3-bit colour levels, registered, zero outside the visible area
//   vblank         high for output lines 480..524
//   palWrEn/palWrIdx/palWrData  palette write port (only with VGA_PALETTE_WR_EN)
//
// Build option: define VGA_PALETTE_WR_EN for a writable palette; otherwise
// the palette is the constant PAL0..PAL3 set and the write ports are absent.

module vga_display_fetch #(
    parameter int unsigned BYTES_PER_ROW = 40,
    parameter logic [8:0]  PAL0          = 9'h000,
    parameter logic [8:0]  PAL1          = 9'h007,
    parameter logic [8:0]  PAL2          = 9'h038,
    parameter logic [8:0]  PAL3          = 9'h1FF
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef VGA_PALETTE_WR_EN
    input  logic        palWrEn,
    input  logic [1:0]  palWrIdx,
    input  logic [8:0]  palWrData,
`endif
    output logic [12:0] displayAddr,
    input  logic [7:0]  displayRdData,
    output logic        hsync,
    output logic        vsync,
    output logic [2:0]  red,
    output logic [2:0]  green,
    output logic [2:0]  blue,
    output logic        vblank
);

    localparam logic [9:0] H_VIS        = 10'd640;
    localparam logic [9:0] H_SYNC_FIRST = 10'd656;
    localparam logic [9:0] H_SYNC_LAST  = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VIS        = 10'd480;
    localparam logic [9:0] V_SYNC_FIRST = 10'd490;
    localparam logic [9:0] V_SYNC_LAST  = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

    // Groups 1..39 are fetched at h = 16g-4 and loaded at h = 16g-1.
    // Group 0 of the next line is fetched/loaded at the end of this line.
    localparam logic [9:0] H_FETCH_LAST = 10'd620;
    localparam logic [9:0] H_LOAD_LAST  = 10'd623;
    localparam logic [9:0] H_PREFETCH   = 10'd796;

    // ------------------------------------------------------------
    // Position counters
    // ------------------------------------------------------------
    logic [9:0] h;
    logic [9:0] v;
    logic [9:0] v_next;
    logic       h_last;
    logic       v_last;

    always_comb begin
        h_last = (h == H_LAST);
        v_last = (v == V_LAST);
        v_next = v_last ? 10'd0 : v + 10'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h <= '0;
            v <= '0;
        end else if (h_last) begin
            h <= '0;
            v <= v_next;
        end else begin
            h <= h + 10'd1;
        end
    end

    // ------------------------------------------------------------
    // Fetch schedule
    // ------------------------------------------------------------
    logic       vis_line;
    logic       pre_ok;
    logic       fetch_mid;
    logic       fetch_pre;
    logic       load_mid;
    logic       load_pre;
    logic [9:0] v_src;
    logic [7:0] row;
    logic [5:0] grp;
    logic [12:0] addr;

    always_comb begin
        vis_line  = (v < V_VIS);
        // The end-of-line prefetch is only useful when the next line is visible;
        // line 524 prefetches row 0 for the top of the next frame.
        pre_ok    = (v < V_VIS - 10'd1) || v_last;
        fetch_mid = vis_line && (h[3:0] == 4'd12) && (h <= H_FETCH_LAST);
        fetch_pre = pre_ok && (h == H_PREFETCH);
        load_mid  = vis_line && (h[3:0] == 4'd15) && (h <= H_LOAD_LAST);
        load_pre  = pre_ok && h_last;
        v_src     = fetch_pre ? v_next : v;
        row       = 8'(v_src >> 2);
        grp       = fetch_pre ? 6'd0 : 6'(h >> 4) + 6'd1;
    end

    generate
        if (BYTES_PER_ROW == 40) begin : g_shift_add
            // row*40 = row*32 + row*8
            assign addr = (13'(row) << 5) + (13'(row) << 3) + 13'(grp);
        end else begin : g_mul
            assign addr = 13'(32'(row) * BYTES_PER_ROW) + 13'(grp);
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            displayAddr <= '0;
        end else if (fetch_mid || fetch_pre) begin
            displayAddr <= addr;
        end
    end

    // ------------------------------------------------------------
    // Pixel byte register; holds the byte for the whole 16-pixel group
    // and the 2-bit index is picked by h[3:2] rather than shifting.
    // ------------------------------------------------------------
    logic [7:0] shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift <= '0;
        end else if (load_mid || load_pre) begin
            shift <= displayRdData;
        end
    end

    logic [1:0] pix;

    always_comb begin
        pix = 2'd0;
        unique case (h[3:2])
            2'd0: pix = shift[7:6];
            2'd1: pix = shift[5:4];
            2'd2: pix = shift[3:2];
            2'd3: pix = shift[1:0];
        endcase
    end

    // ------------------------------------------------------------
    // Palette
    // ------------------------------------------------------------
    logic [8:0] pal [4];

`ifdef VGA_PALETTE_WR_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pal[0] <= PAL0;
            pal[1] <= PAL1;
            pal[2] <= PAL2;
            pal[3] <= PAL3;
        end else if (palWrEn) begin
            pal[palWrIdx] <= palWrData;
        end
    end
`else
    always_comb begin
        pal[0] = PAL0;
        pal[1] = PAL1;
        pal[2] = PAL2;
        pal[3] = PAL3;
    end
`endif

    logic [8:0] colour;
    logic       visible;

    always_comb begin
        visible = (h < H_VIS) && vis_line;
        colour  = visible ? pal[pix] : 9'd0;
    end

    // ------------------------------------------------------------
    // Registered outputs: all reflect the position of the previous cycle
    // ------------------------------------------------------------
    logic [8:0] rgb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync  <= 1'b1;
            vsync  <= 1'b1;
            vblank <= 1'b0;
            rgb    <= '0;
        end else begin
            hsync  <= !((h >= H_SYNC_FIRST) && (h <= H_SYNC_LAST));
            vsync  <= !((v >= V_SYNC_FIRST) && (v <= V_SYNC_LAST));
            vblank <= !vis_line;
            rgb    <= colour;
        end
    end

    assign red   = rgb[8:6];
    assign green = rgb[5:3];
    assign blue  = rgb[2:0];

endmodule
